// File: rtl/simd_pkg.sv
// simd_pkg: shared opcode, field-position and decoded-instruction definitions for the SIMD front end
// Contents: opcode_e enum, instruction field bit positions, dec_t decoded struct, decode() helper
package simd_pkg;

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_VADD = 6'd1,
        OP_VSUB = 6'd2,
        OP_VMUL = 6'd3,
        OP_VMAC = 6'd4,
        OP_VLD  = 6'd5,
        OP_VST  = 6'd6,
        OP_HALT = 6'd63
    } opcode_e;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int EW_HI  = 10;
    localparam int EW_LO  = 9;
    localparam int IMM_HI = 8;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  ewidth;
        logic [15:0] imm;
        logic        illegal;
        logic        writer;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.opcode  = instr[OPC_HI:OPC_LO];
        d.rd      = instr[RD_HI:RD_LO];
        d.rs1     = instr[RS1_HI:RS1_LO];
        d.rs2     = instr[RS2_HI:RS2_LO];
        d.ewidth  = instr[EW_HI:EW_LO];
        d.imm     = {{7{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
        d.illegal = !(d.opcode inside {OP_NOP, OP_VADD, OP_VSUB, OP_VMUL, OP_VMAC, OP_VLD, OP_VST, OP_HALT})
                    || d.ewidth == 2'b11;
        d.writer  = !d.illegal && (d.opcode inside {OP_VADD, OP_VSUB, OP_VMUL, OP_VMAC, OP_VLD});
        return d;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: per-register busy bits for in-flight destination writes
// Ports: clk, reset (async high); set_i/set_idx_i mark busy; clr_i/clr_idx_i writeback release;
//        fl_i/fl_idx_i release on flush; busy_o current busy vector (bit 0 always 0)
module decode_scoreboard #(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_i,
    input  logic [4:0]      set_idx_i,
    input  logic            clr_i,
    input  logic [4:0]      clr_idx_i,
    input  logic            fl_i,
    input  logic [4:0]      fl_idx_i,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q, busy_d;

    // set is applied last so a new claim beats a same-cycle release of that register
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_idx_i] = 1'b0;
        if (fl_i) busy_d[fl_idx_i] = 1'b0;
        if (set_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: one-deep decode register between fetch and execute with RAW/WAW scoreboard
// Ports: clk, reset (async high); fetch_* valid/ready instruction input; dec_* valid/ready decoded output;
//        wb_valid/wb_rd register release; flush kills the held instruction; halted set once HALT is taken
module instruction_decode
    import simd_pkg::*;
#(
    parameter int PC_W = 16,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid,
    input  logic [31:0]     fetch_instr,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            fetch_ready,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [5:0]      dec_opcode,
    output logic [4:0]      dec_rd,
    output logic [4:0]      dec_rs1,
    output logic [4:0]      dec_rs2,
    output logic [1:0]      dec_ewidth,
    output logic [15:0]     dec_imm,
    output logic [PC_W-1:0] dec_pc,
    output logic            dec_illegal,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic            halted
);

    dec_t            fd, dec_q, dec_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d, halted_q, halted_d;
    logic [NREG-1:0] busy, busy_fwd;
    logic            hazard, xfer;

    assign fd = decode(fetch_instr);

    // a register released by writeback this cycle is treated as free already
    assign busy_fwd    = busy & ~(NREG'(wb_valid) << wb_rd);
    assign hazard      = busy_fwd[fd.rs1] | busy_fwd[fd.rs2] | (fd.writer & busy_fwd[fd.rd]);
    assign fetch_ready = !halted_q && !flush && !hazard && (!valid_q || dec_ready);
    assign xfer        = fetch_valid && fetch_ready;

    always_comb begin
        dec_d    = xfer ? fd : dec_q;
        pc_d     = xfer ? fetch_pc : pc_q;
        valid_d  = flush ? 1'b0 : xfer ? 1'b1 : dec_ready ? 1'b0 : valid_q;
        halted_d = halted_q | (xfer && fd.opcode == OP_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_q    <= '0;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            dec_q    <= dec_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    decode_scoreboard #(.NREG(NREG)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_i     (xfer && fd.writer),
        .set_idx_i (fd.rd),
        .clr_i     (wb_valid),
        .clr_idx_i (wb_rd),
        .fl_i      (flush && valid_q && dec_q.writer),
        .fl_idx_i  (dec_q.rd),
        .busy_o    (busy)
    );

    assign dec_valid   = valid_q;
    assign dec_opcode  = dec_q.opcode;
    assign dec_rd      = dec_q.rd;
    assign dec_rs1     = dec_q.rs1;
    assign dec_rs2     = dec_q.rs2;
    assign dec_ewidth  = dec_q.ewidth;
    assign dec_imm     = dec_q.imm;
    assign dec_pc      = pc_q;
    assign dec_illegal = dec_q.illegal;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed vectors with hand-computed expectations for instruction_decode
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset, fetch_valid, fetch_ready, dec_valid, dec_ready, dec_illegal;
    logic        wb_valid, flush, halted;
    logic [31:0] fetch_instr;
    logic [15:0] fetch_pc, dec_pc, dec_imm;
    logic [5:0]  dec_opcode;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2, wb_rd;
    logic [1:0]  dec_ewidth;
    int          tests = 0;
    int          fails = 0;

    instruction_decode #(.PC_W(16), .NREG(32)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_ewidth(dec_ewidth), .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_illegal(dec_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [1:0] ew, input logic [8:0] imm);
        return {op, rd, rs1, rs2, ew, imm};
    endfunction

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
        dec_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset arriving while an instruction is held and another is offered
        reset = 1'b0; fetch_valid = 1'b1; fetch_instr = enc(6'd3, 5'd5, 5'd0, 5'd0, 2'd0, 9'd0); fetch_pc = 16'h10;
        tick();
        check("pre_rst_valid", 32'(dec_valid), 32'd1);
        check("pre_rst_busy", dut.busy, 32'h20);
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_busy", dut.busy, 32'h0);
        check("rst_opcode", 32'(dec_opcode), 32'd0);
        check("rst_rd", 32'(dec_rd), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        tick();
        check("rst_hold_valid", 32'(dec_valid), 32'd0);
        // VADD rd=3 rs1=1 rs2=2 ew=01 imm=0x1FF taken on the first edge after reset release
        reset = 1'b0; fetch_instr = enc(6'd1, 5'd3, 5'd1, 5'd2, 2'b01, 9'h1FF); fetch_pc = 16'h20;
        #1;
        check("fr_after_rst", 32'(fetch_ready), 32'd1);
        tick();
        fetch_valid = 1'b0;
        check("vadd_valid", 32'(dec_valid), 32'd1);
        check("vadd_opcode", 32'(dec_opcode), 32'd1);
        check("vadd_rd", 32'(dec_rd), 32'd3);
        check("vadd_rs1", 32'(dec_rs1), 32'd1);
        check("vadd_rs2", 32'(dec_rs2), 32'd2);
        check("vadd_ew", 32'(dec_ewidth), 32'd1);
        check("vadd_imm", 32'(dec_imm), 32'hFFFF);
        check("vadd_pc", 32'(dec_pc), 32'h20);
        check("vadd_illegal", 32'(dec_illegal), 32'd0);
        check("vadd_busy", dut.busy, 32'h8);
        // VSUB reading r3 stalls until r3 is written back
        dec_ready = 1'b1; fetch_valid = 1'b1; fetch_instr = enc(6'd2, 5'd4, 5'd3, 5'd0, 2'd0, 9'd0); fetch_pc = 16'h24;
        #1;
        check("haz_fr0", 32'(fetch_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("haz_fr", 32'(fetch_ready), 32'd0);
            check("haz_valid", 32'(dec_valid), 32'd0);
        end
        wb_valid = 1'b1; wb_rd = 5'd3;
        #1;
        check("haz_bypass_fr", 32'(fetch_ready), 32'd1);
        tick();
        wb_valid = 1'b0; fetch_valid = 1'b0;
        check("vsub_valid", 32'(dec_valid), 32'd1);
        check("vsub_opcode", 32'(dec_opcode), 32'd2);
        check("vsub_rd", 32'(dec_rd), 32'd4);
        check("vsub_busy", dut.busy, 32'h10);
        wb_valid = 1'b1; wb_rd = 5'd4;
        tick();
        wb_valid = 1'b0;
        check("wb4_busy", dut.busy, 32'h0);
        // back-pressure: A held for 4 cycles while B waits
        dec_ready = 1'b0; fetch_valid = 1'b1; fetch_instr = enc(6'd1, 5'd8, 5'd1, 5'd2, 2'd0, 9'd5); fetch_pc = 16'h30;
        tick();
        check("bp_a_rd", 32'(dec_rd), 32'd8);
        fetch_instr = enc(6'd1, 5'd9, 5'd1, 5'd2, 2'd0, 9'd6); fetch_pc = 16'h34;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_fr", 32'(fetch_ready), 32'd0);
            tick();
            check("bp_rd", 32'(dec_rd), 32'd8);
            check("bp_pc", 32'(dec_pc), 32'h30);
            check("bp_imm", 32'(dec_imm), 32'd5);
            check("bp_valid", 32'(dec_valid), 32'd1);
        end
        dec_ready = 1'b1;
        #1;
        check("bp_release_fr", 32'(fetch_ready), 32'd1);
        tick();
        fetch_valid = 1'b0;
        check("bp_b_rd", 32'(dec_rd), 32'd9);
        check("bp_b_pc", 32'(dec_pc), 32'h34);
        check("bp_b_valid", 32'(dec_valid), 32'd1);
        check("bp_busy", dut.busy, 32'h300);
        tick();
        check("bp_no_dup", 32'(dec_valid), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd8;
        tick();
        wb_rd = 5'd9;
        tick();
        wb_valid = 1'b0;
        check("wb89_busy", dut.busy, 32'h0);
        // flush of a held VMUL rd=7 releases r7
        dec_ready = 1'b0; fetch_valid = 1'b1; fetch_instr = enc(6'd3, 5'd7, 5'd1, 5'd2, 2'd0, 9'd0); fetch_pc = 16'h40;
        tick();
        fetch_valid = 1'b0;
        check("vmul_valid", 32'(dec_valid), 32'd1);
        check("vmul_busy", dut.busy, 32'h80);
        flush = 1'b1;
        #1;
        check("flush_fr", 32'(fetch_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_valid", 32'(dec_valid), 32'd0);
        check("flush_busy", dut.busy, 32'h0);
        // claim of r13 coinciding with a writeback of r13: claim wins
        dec_ready = 1'b1; fetch_valid = 1'b1; fetch_instr = enc(6'd1, 5'd13, 5'd0, 5'd0, 2'd0, 9'd0);
        wb_valid = 1'b1; wb_rd = 5'd13;
        tick();
        wb_valid = 1'b0; fetch_valid = 1'b0;
        check("setwin_busy", dut.busy, 32'h2000);
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        check("wb13_busy", dut.busy, 32'h0);
        // illegal opcode and illegal element width claim nothing
        fetch_valid = 1'b1; fetch_instr = enc(6'd20, 5'd10, 5'd0, 5'd0, 2'd0, 9'd0);
        tick();
        check("ill_op", 32'(dec_illegal), 32'd1);
        check("ill_op_busy", dut.busy, 32'h0);
        fetch_instr = enc(6'd1, 5'd11, 5'd0, 5'd0, 2'b11, 9'd0);
        tick();
        check("ill_ew", 32'(dec_illegal), 32'd1);
        check("ill_ew_opcode", 32'(dec_opcode), 32'd1);
        check("ill_ew_busy", dut.busy, 32'h0);
        // VLD to r0 never marks r0; an r0 reader follows without stall
        fetch_instr = enc(6'd5, 5'd0, 5'd0, 5'd0, 2'd0, 9'd0);
        tick();
        check("vld0_valid", 32'(dec_valid), 32'd1);
        check("vld0_opcode", 32'(dec_opcode), 32'd5);
        check("vld0_busy", dut.busy, 32'h0);
        fetch_instr = enc(6'd1, 5'd12, 5'd0, 5'd0, 2'd0, 9'd0);
        #1;
        check("r0_fr", 32'(fetch_ready), 32'd1);
        tick();
        fetch_valid = 1'b0;
        check("r0_rd", 32'(dec_rd), 32'd12);
        check("r0_busy", dut.busy, 32'h1000);
        wb_valid = 1'b1; wb_rd = 5'd12;
        tick();
        wb_valid = 1'b0;
        // HALT stops intake until reset
        fetch_valid = 1'b1; fetch_instr = enc(6'd63, 5'd0, 5'd0, 5'd0, 2'd0, 9'd0);
        tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_opcode", 32'(dec_opcode), 32'd63);
        check("halt_valid", 32'(dec_valid), 32'd1);
        fetch_instr = enc(6'd1, 5'd14, 5'd0, 5'd0, 2'd0, 9'd0);
        #1;
        check("halt_fr", 32'(fetch_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_fr_hold", 32'(fetch_ready), 32'd0);
            check("halt_hold", 32'(halted), 32'd1);
            check("halt_no_xfer", 32'(dec_valid), 32'd0);
        end
        reset = 1'b1;
        #1;
        check("halt_rst", 32'(halted), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("halt_rst_fr", 32'(fetch_ready), 32'd1);
        tick();
        fetch_valid = 1'b0;
        check("post_halt_valid", 32'(dec_valid), 32'd1);
        check("post_halt_rd", 32'(dec_rd), 32'd14);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter PC_W, 16, fetch PC width.
REQ-002 SHALL have parameter NREG, 32, vector register count; register index 5 bits.
REQ-003 SHALL have port clk input 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset input 1, asynchronous active-high reset.
REQ-005 SHALL have ports fetch_valid input 1, fetch_instr input 32, fetch_pc input PC_W, fetch_ready output 1, instruction stream from instruction_fetch.
REQ-006 SHALL have ports dec_valid output 1, dec_ready input 1, handshake to execute stage.
REQ-007 SHALL have ports dec_opcode output 6, dec_rd/dec_rs1/dec_rs2 output 5 each, dec_ewidth output 2, dec_imm output 16, dec_pc output PC_W, dec_illegal output 1, decoded fields.
REQ-008 SHALL have ports wb_valid input 1, wb_rd input 5, writeback release of a destination register.
REQ-009 SHALL have ports flush input 1, kill held instruction, and halted output 1, HALT retired into decode.

Function
REQ-010 SHALL decode fields: opcode=[31:26], rd=[25:21], rs1=[20:16], rs2=[15:11], ewidth=[10:9], imm=sign-extend([8:0]) to 16 bits.
REQ-011 SHALL treat opcodes NOP=0, VADD=1, VSUB=2, VMUL=3, VMAC=4, VLD=5, VST=6, HALT=63 as legal; all others, or ewidth=11, set dec_illegal=1.
REQ-012 SHALL classify VADD/VSUB/VMUL/VMAC/VLD as writers of rd; NOP, VST, HALT, illegal as non-writers.
REQ-013 SHALL transfer on fetch_valid&&fetch_ready; transfer loads output register and sets dec_valid next cycle (latency 1).
REQ-014 SHALL hold all dec_* outputs stable while dec_valid&&!dec_ready.
REQ-015 SHALL drive fetch_ready = !halted && !flush && !hazard && (!dec_valid || dec_ready), combinationally.
REQ-016 SHALL keep a NREG-bit busy scoreboard; register 0 never busy.
REQ-017 SHALL assert hazard when rs1, rs2, or (writer) rd of fetch_instr is busy, where a bit being cleared by wb_valid/wb_rd in the same cycle counts as not busy (bypass).
REQ-018 SHALL set busy[rd] on transfer of a writer with rd!=0; same-cycle set and wb clear on same index: set wins.
REQ-019 SHALL clear busy[wb_rd] on wb_valid when no conflicting set.
REQ-020 SHALL on flush clear dec_valid next cycle and clear busy[dec_rd] if held instruction is a valid writer; no transfer that cycle.
REQ-021 SHALL on transfer of HALT set halted, forcing fetch_ready=0 until reset; HALT itself still presented on dec_* side.
REQ-022 SHALL drop a transfer when dec_valid && !dec_ready (no overwrite; guaranteed by fetch_ready).

Reset
REQ-023 SHALL on reset clear dec_valid, halted, busy to 0, and dec_* fields to 0, immediately, regardless of in-flight handshake.
REQ-024 SHALL resume accepting on first rising edge after reset deasserts.

Structure
REQ-025 SHALL place opcode constants, opcode enum, field position constants, and decoded-instruction struct typedef in shared package simd_pkg.
REQ-026 SHALL implement scoreboard as sub-module decode_scoreboard (set, clear, flush-clear, busy vector).
REQ-027 SHALL fit 120-400 lines RTL total.

Verification
REQ-028 Bench SHALL check: reset mid-handshake, then VADD rd=3 rs1=1 rs2=2 ewidth=01 imm=0x1FF -> one cycle later dec_valid=1, dec_opcode=1, dec_rd=3, dec_imm=16'hFFFF, busy[3]=1.
REQ-029 Bench SHALL check: VADD rd=3 followed by VSUB rs1=3 -> fetch_ready=0 until wb_valid wb_rd=3; accepted in that same cycle.
REQ-030 Bench SHALL check: dec_ready=0 for 4 cycles with fetch_valid=1 -> outputs unchanged, fetch_ready=0, no instruction lost or duplicated.
REQ-031 Bench SHALL check: flush while holding VMUL rd=7 -> dec_valid=0 next cycle, busy[7]=0.
REQ-032 Bench SHALL check: opcode 20 and VADD with ewidth=11 -> dec_illegal=1, no busy bit set; HALT -> halted=1, fetch_ready=0 until reset.
REQ-033 Bench SHALL check: VLD rd=0 -> busy stays 0; subsequent rs1=0 instruction accepted without stall.
